// File: rtl/div_reconstructor_if.sv
// Start/done handshake and operand/result bundle for the divider reconstructor.
// The master side drives the quotient/divisor/remainder triple and start;
// the slave side returns the reconstructed dividend and status flags.
interface div_reconstructor_if #(
  parameter int SIZE = 32
) ();
  logic            start;
  logic [SIZE-1:0] cociente;
  logic [SIZE-1:0] denominador;
  logic [SIZE-1:0] resto;
  logic [SIZE-1:0] numerador;
  logic            overflow;
  logic            invalid;
  logic            done;

  modport master (
    output start, cociente, denominador, resto,
    input  numerador, overflow, invalid, done
  );

  modport slave (
    input  start, cociente, denominador, resto,
    output numerador, overflow, invalid, done
  );
endinterface

// File: rtl/div_reconstructor.sv
// Sequential shift-add reconstructor: numerador = cociente * denominador + resto.
// Runs SIZE multiply iterations followed by one add/flag cycle, so a result
// appears a fixed SIZE+1 cycles after start regardless of operand values.
// The accumulator is 2*SIZE+1 bits so the overflow flag is exact.
module div_reconstructor #(
  parameter int SIZE = 32
) (
  input logic               clk,
  input logic               rst_n,
  div_reconstructor_if.slave bus
);

  localparam int              CW   = $clog2(SIZE);
  localparam logic [CW-1:0]   LAST = CW'(SIZE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] ADD  = 2'd2;

  logic [1:0]        state;
  logic [SIZE-1:0]   q;
  logic [2*SIZE-1:0] d;
  logic [SIZE-1:0]   r;
  logic [SIZE-1:0]   den;
  logic [2*SIZE:0]   acc;
  logic [CW-1:0]     count;
  logic [2*SIZE:0]   sum;

  logic [SIZE-1:0]   numerador;
  logic              overflow;
  logic              invalid;
  logic              done;

  assign bus.numerador = numerador;
  assign bus.overflow  = overflow;
  assign bus.invalid   = invalid;
  assign bus.done      = done;

  // Final product plus remainder, consumed in the ADD cycle.
  always_comb begin
    sum = acc + {{(SIZE + 1){1'b0}}, r};
  end

  // Control FSM, operand/accumulator datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= {SIZE{1'b0}};
      d         <= {(2 * SIZE){1'b0}};
      r         <= {SIZE{1'b0}};
      den       <= {SIZE{1'b0}};
      acc       <= {(2 * SIZE + 1){1'b0}};
      count     <= {CW{1'b0}};
      numerador <= {SIZE{1'b0}};
      overflow  <= 1'b0;
      invalid   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle is an IDLE cycle, so back-to-back starts are taken here.
          if (bus.start) begin
            q     <= bus.cociente;
            d     <= {{SIZE{1'b0}}, bus.denominador};
            r     <= bus.resto;
            den   <= bus.denominador;
            acc   <= {(2 * SIZE + 1){1'b0}};
            count <= {CW{1'b0}};
            state <= MULT;
          end
        end
        MULT: begin
          // No early exit when q runs out of ones: latency stays fixed.
          if (q[0]) begin
            acc <= acc + {1'b0, d};
          end
          q     <= q >> 1;
          d     <= d << 1;
          count <= count + CW'(1);
          if (count == LAST) begin
            state <= ADD;
          end
        end
        ADD: begin
          numerador <= sum[SIZE-1:0];
          overflow  <= |sum[2*SIZE:SIZE];
          invalid   <= (r >= den);
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
